// File: rtl/cv32e40p_core_v_xif_pkg.sv
// -----------------------------------------------------------------------------
// cv32e40p_core_v_xif_pkg
// Shared types and defaults for the X-interface result writeback path.
//   x_result_entry_t : one buffered coprocessor result
//                      {id, data, rd, we, exc, exccode}
//   X_RESULT_*_DEFAULT : default FIFO depth / starvation limit / ID width
// The id field is sized to X_ID_MAX_W so that the struct is independent of
// the ID_W parameter of the blocks that use it. Users zero-extend on the way
// in and keep only their low ID_W bits on the way out (ID_W <= X_ID_MAX_W).
// -----------------------------------------------------------------------------
package cv32e40p_core_v_xif_pkg;

  localparam int unsigned X_RESULT_DEPTH_DEFAULT        = 4;
  localparam int unsigned X_RESULT_STARVE_LIMIT_DEFAULT = 8;
  localparam int unsigned X_ID_W_DEFAULT                = 4;
  localparam int unsigned X_ID_MAX_W                    = 16;

  typedef struct packed {
    logic [X_ID_MAX_W-1:0] id;
    logic [31:0]           data;
    logic [4:0]            rd;
    logic                  we;
    logic                  exc;
    logic [5:0]            exccode;
  } x_result_entry_t;

endpackage

// File: rtl/cv32e40p_x_result_fifo.sv
// -----------------------------------------------------------------------------
// cv32e40p_x_result_fifo
// Synchronous in-order FIFO of x_result_entry_t with a combinational head.
//   clk_i, rst_i : clock, synchronous active-high reset (flushes the FIFO)
//   push_i       : write entry_i at the tail (ignored when full)
//   entry_i      : entry to store
//   pop_i        : drop the head entry (ignored when empty)
//   head_o       : current head entry, valid while empty_o=0
//   full_o       : occupancy == DEPTH (registered state only)
//   empty_o      : occupancy == 0     (registered state only)
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module cv32e40p_x_result_fifo
  import cv32e40p_core_v_xif_pkg::*;
#(
  parameter int unsigned DEPTH = X_RESULT_DEPTH_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  x_result_entry_t entry_i,
  input  logic            pop_i,
  output x_result_entry_t head_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  x_result_entry_t  mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o & ~rst_i;
  assign pop_ok  = pop_i & ~empty_o & ~rst_i;
  assign head_o  = mem_q[head_q];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_ok) tail_d = tail_q + PTR_W'(1);
    if (pop_ok)  head_d = head_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage has no reset: stale contents are never visible because the
  // occupancy counter is flushed.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk_i) begin
        if (push_ok && (tail_q == PTR_W'(gi))) begin
          mem_q[gi] <= entry_i;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/cv32e40p_x_result_wb.sv
// -----------------------------------------------------------------------------
// cv32e40p_x_result_wb
// X-interface result channel writeback. Buffers coprocessor results in an
// in-order FIFO and retires them onto the register-file write port in cycles
// where the core's own WB stage is not writing.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   x_result_*_i/_o     : result channel (valid/ready handshake + payload)
//   core_we_wb_i        : core WB owns the RF write port this cycle
//   rf_we_o/waddr/wdata : register-file write port
//   sb_clr_valid_o/rd_o : pulse telling the dispatcher to clear a scoreboard bit
//   exc_valid_o/code/id : pulse for a retired result carrying an exception
//   id_err_o            : sticky, a result arrived with an unexpected ID
//   wb_stall_o          : results have been starved of the write port
// Optional: define CV32E40P_X_RESULT_BYPASS_EN to retire a result in its
// arrival cycle when the FIFO is empty and the write port is free.
// -----------------------------------------------------------------------------
module cv32e40p_x_result_wb
  import cv32e40p_core_v_xif_pkg::*;
#(
  parameter int unsigned DEPTH        = X_RESULT_DEPTH_DEFAULT,
  parameter int unsigned STARVE_LIMIT = X_RESULT_STARVE_LIMIT_DEFAULT,
  parameter int unsigned ID_W         = X_ID_W_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            x_result_valid_i,
  output logic            x_result_ready_o,
  input  logic [ID_W-1:0] x_result_id_i,
  input  logic [31:0]     x_result_data_i,
  input  logic [4:0]      x_result_rd_i,
  input  logic            x_result_we_i,
  input  logic            x_result_exc_i,
  input  logic [5:0]      x_result_exccode_i,
  input  logic            core_we_wb_i,
  output logic            rf_we_o,
  output logic [4:0]      rf_waddr_o,
  output logic [31:0]     rf_wdata_o,
  output logic            sb_clr_valid_o,
  output logic [4:0]      sb_clr_rd_o,
  output logic            exc_valid_o,
  output logic [5:0]      exc_code_o,
  output logic [ID_W-1:0] exc_id_o,
  output logic            id_err_o,
  output logic            wb_stall_o
);

  localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);

  x_result_entry_t in_entry;
  x_result_entry_t head;
  x_result_entry_t ret_entry;
  logic            full, empty;
  logic            accept, push, pop, bypass, retire;

  logic [ID_W-1:0] exp_id_q, exp_id_d;
  logic            id_err_q, id_err_d;
  logic [SC_W-1:0] starve_q, starve_d;
  logic            wb_stall_q, wb_stall_d;
  logic            unused_id_bits;

  always_comb begin
    in_entry         = '0;
    in_entry.id      = X_ID_MAX_W'(x_result_id_i);
    in_entry.data    = x_result_data_i;
    in_entry.rd      = x_result_rd_i;
    in_entry.we      = x_result_we_i;
    in_entry.exc     = x_result_exc_i;
    in_entry.exccode = x_result_exccode_i;
  end

  // Ready depends on registered occupancy only (plus reset), never on the
  // same-cycle pop, so a full FIFO refuses a push even while draining.
  assign x_result_ready_o = ~rst_i & ~full;
  assign accept           = x_result_valid_i & x_result_ready_o;

`ifdef CV32E40P_X_RESULT_BYPASS_EN
  assign bypass = ~rst_i & empty & ~core_we_wb_i & x_result_valid_i;
`else
  assign bypass = 1'b0;
`endif

  assign push      = accept & ~bypass;
  assign pop       = ~rst_i & ~empty & ~core_we_wb_i;
  assign retire    = pop | bypass;
  assign ret_entry = pop ? head : in_entry;

  // Only the low ID_W bits of the stored ID are meaningful.
  assign unused_id_bits = ^ret_entry.id;

  cv32e40p_x_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .entry_i (in_entry),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // Retirement decode; every payload output reads 0 unless its valid is set.
  always_comb begin
    rf_we_o        = 1'b0;
    rf_waddr_o     = '0;
    rf_wdata_o     = '0;
    sb_clr_valid_o = 1'b0;
    sb_clr_rd_o    = '0;
    exc_valid_o    = 1'b0;
    exc_code_o     = '0;
    exc_id_o       = '0;
    if (retire) begin
      if (ret_entry.exc) begin
        exc_valid_o    = 1'b1;
        exc_code_o     = ret_entry.exccode;
        exc_id_o       = ret_entry.id[ID_W-1:0];
        sb_clr_valid_o = ret_entry.we;
        sb_clr_rd_o    = ret_entry.we ? ret_entry.rd : 5'd0;
      end else if (ret_entry.we) begin
        sb_clr_valid_o = 1'b1;
        sb_clr_rd_o    = ret_entry.rd;
        rf_we_o        = (ret_entry.rd != 5'd0);
        rf_waddr_o     = ret_entry.rd;
        rf_wdata_o     = ret_entry.data;
      end
    end
  end

  // ID tracking: on every accepted result the expectation becomes id+1,
  // which both advances on a match and resyncs after a mismatch.
  always_comb begin
    exp_id_d = exp_id_q;
    id_err_d = id_err_q;
    if (accept) begin
      exp_id_d = x_result_id_i + ID_W'(1);
      if (x_result_id_i != exp_id_q) id_err_d = 1'b1;
    end
  end

  // Starvation: count consecutive cycles with a waiting result and a busy
  // write port. Any other cycle is either empty or a pop, both of which clear.
  always_comb begin
    starve_d   = '0;
    wb_stall_d = wb_stall_q;
    if (~empty && core_we_wb_i) begin
      starve_d = (starve_q == SC_W'(STARVE_LIMIT)) ? starve_q : starve_q + SC_W'(1);
    end
    if (pop) begin
      wb_stall_d = 1'b0;
    end else if (starve_q == SC_W'(STARVE_LIMIT)) begin
      wb_stall_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exp_id_q   <= '0;
      id_err_q   <= 1'b0;
      starve_q   <= '0;
      wb_stall_q <= 1'b0;
    end else begin
      exp_id_q   <= exp_id_d;
      id_err_q   <= id_err_d;
      starve_q   <= starve_d;
      wb_stall_q <= wb_stall_d;
    end
  end

  assign id_err_o   = id_err_q & ~rst_i;
  assign wb_stall_o = wb_stall_q & ~rst_i;

endmodule

// File: doc/cv32e40p_x_result_wb.md
Name: cv32e40p_x_result_wb

Overview:
- Consumes the X-interface result channel downstream of the offload dispatcher.
- Buffers coprocessor results in a small in-order FIFO and arbitrates them onto the register-file write port whenever the core's own WB stage is not writing.
- Reports each completed writeback back to the dispatcher so it can clear its scoreboard bit.
- Reports coprocessor exceptions and result-ID ordering errors, and requests a core stall if results are starved of the write port.

Parameters:
- DEPTH, 4, number of result FIFO entries; power of two, ≥2.
- STARVE_LIMIT, 8, consecutive blocked cycles before a stall is requested; ≥1.
- ID_W, 4, width of the result/issue ID.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- x_result_valid_i  in  1  result channel valid.
- x_result_ready_o  out  1  result channel ready.
- x_result_id_i  in  ID_W  result ID.
- x_result_data_i  in  32  result data.
- x_result_rd_i  in  5  destination register.
- x_result_we_i  in  1  result writes rd.
- x_result_exc_i  in  1  result carries an exception.
- x_result_exccode_i  in  6  exception code.
- core_we_wb_i  in  1  core WB stage owns the RF write port this cycle.
- rf_we_o  out  1  RF write enable.
- rf_waddr_o  out  5  RF write address.
- rf_wdata_o  out  32  RF write data.
- sb_clr_valid_o  out  1  pulse: scoreboard bit may be cleared.
- sb_clr_rd_o  out  5  register to clear.
- exc_valid_o  out  1  pulse: exception result retired.
- exc_code_o  out  6  exception code.
- exc_id_o  out  ID_W  ID of the faulting result.
- id_err_o  out  1  sticky: out-of-order result ID detected.
- wb_stall_o  out  1  request to stall the core pipeline.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - Flushes the FIFO.
  - Clears the expected-ID counter, starve counter, id_err_o and wb_stall_o.
  - While rst_i is high, all outputs are 0, including x_result_ready_o.
  - Reset mid-operation discards buffered results; no writeback occurs for them.
- Handshake:
  - x_result_ready_o = ~full.
  - It is derived only from registered occupancy: there is no combinational path from valid, core_we_wb_i or the same-cycle pop.
  - Push on valid&ready stores {id, data, rd, we, exc, exccode}.
  - When full, no push occurs even if a pop happens the same cycle.
- Pop:
  - Pops the head when non-empty and core_we_wb_i=0.
  - Outputs are combinational from the head in the pop cycle.
  - Minimum latency: accept at cycle t, writeback at t+1.
- Per popped entry:
  - exc=1: rf_we_o=0; exc_valid_o=1 with exc_code_o/exc_id_o from the entry; sb_clr_valid_o=we.
  - exc=0, we=1: sb_clr_valid_o=1, sb_clr_rd_o=rd; rf_we_o=(rd≠0), rf_waddr_o=rd, rf_wdata_o=data.
  - we=0: pop only; no RF write, no sb_clr.
- ID ordering:
  - The expected-ID counter (ID_W bits, wraps 2^ID_W-1→0) increments on every push.
  - A push with x_result_id_i≠expected sets id_err_o, which stays high until reset.
  - The entry is still buffered and the counter resyncs to id+1.
- Starvation:
  - The starve counter increments each cycle the FIFO is non-empty and core_we_wb_i=1, saturating at STARVE_LIMIT.
  - It clears on any pop or when the FIFO is empty.
  - wb_stall_o is registered: 1 from the cycle after the counter reaches STARVE_LIMIT, until the cycle after the next pop.
- Occupancy: a counter of log2(DEPTH)+1 bits; head/tail pointers wrap modulo DEPTH.

Optional Feature:
- Macro: CV32E40P_X_RESULT_BYPASS_EN.
- When defined:
  - If the FIFO is empty, core_we_wb_i=0 and x_result_valid_i=1, the result is retired in the same cycle (zero latency) with the same per-entry rules.
  - The result is not pushed, but the expected-ID check still applies.
- When undefined: every result passes through the FIFO (latency ≥1).

Decomposition:
- Shared package cv32e40p_core_v_xif_pkg:
  - x_result_entry_t packed struct {id, data, rd, we, exc, exccode}.
  - Default DEPTH/STARVE_LIMIT constants.
- One sub-module: cv32e40p_x_result_fifo, a generic synchronous FIFO of x_result_entry_t with full/empty/push/pop.

Test Plan:
- Empty FIFO, core_we_wb_i=0, push id=0 rd=5 data=0xDEADBEEF we=1 → next cycle rf_we_o=1, waddr=5, wdata=0xDEADBEEF, sb_clr_valid_o=1 rd=5; same cycle when bypass is enabled.
- Hold core_we_wb_i=1, push 4 results (DEPTH=4) → x_result_ready_o=0 after the 4th; release core_we_wb_i → 4 in-order writebacks on consecutive cycles, then ready=1.
- core_we_wb_i=1 for 10 cycles with 1 entry buffered (STARVE_LIMIT=8) → wb_stall_o rises after 8 blocked cycles; drops the cycle after the pop.
- Push exc=1 exccode=0x02 id=3 → exc_valid_o pulse, code 0x02, id 3, rf_we_o=0.
- Push we=1 rd=0 → rf_we_o=0, sb_clr_valid_o=1 rd=0. Push ids 0,1,3 → id_err_o set at id 3 and held until rst_i.
- Assert rst_i with 3 entries buffered → no writebacks afterwards; ready=1 and all outputs 0 the cycle after reset deasserts.
